sum_sequencer: RTL

Controller that sequences the `sumItUp` adder: it collects a run of operands from an upstream source, streams them to the adder as one contiguous `go_l` burst, waits for `done`, checks the adder's sum against an internal shadow sum, and hands the result to the downstream thread over a valid/ready handshake. It sits between the operand source (test driver or switches) and the `sumItUp` → `downStream` datapath, replacing free-running `go_l` generation.

---
 rtl/sum_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sum_sequencer.sv
// Sequencer for the sumItUp adder: buffers a run of operands, replays them as one
// contiguous go_l burst, then cross-checks the adder's sum against a shadow sum.
module sum_sequencer #(
   parameter int unsigned W       = 8,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic                   ck,
   input  logic                   reset,
   input  logic                   start,
   input  logic [$clog2(DEPTH):0] cnt,
   input  logic                   src_valid,
   input  logic [W-1:0]           src_data,
   output logic                   src_ready,
   output logic                   go_l,
   output logic [W-1:0]           inA,
   input  logic                   done,
   input  logic [W-1:0]           sum,
   output logic                   res_valid,
   output logic [W-1:0]           res_data,
   input  logic                   res_ready,
   output logic                   busy,
   output logic                   mismatch,
   output logic                   timeout_err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DepthC   = CW'(DEPTH);
   localparam logic [TW-1:0] TmoLastC = TW'(TIMEOUT - 1);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StFetch = 3'd1;
   localparam logic [2:0] StFeed  = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StHold  = 3'd4;
   localparam logic [2:0] StErr   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [W-1:0]  shadow_q, shadow_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [W-1:0]  res_data_q, res_data_d;
   logic          mismatch_q, mismatch_d;
   logic          tmo_err_q, tmo_err_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          accept;

   assign accept = (state_q == StFetch) && src_valid;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      shadow_d   = shadow_q;
      tmo_d      = tmo_q;
      res_data_d = res_data_q;
      mismatch_d = mismatch_q;
      tmo_err_d  = tmo_err_q;
      case (state_q)
         // ERR accepts a new run exactly as IDLE does
         StIdle, StErr: begin
            if (start) begin
               mismatch_d = 1'b0;
               tmo_err_d  = 1'b0;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               shadow_d   = '0;
               tmo_d      = '0;
               if (cnt == '0) begin
                  res_data_d = '0;
                  state_d    = StHold;
               end else begin
                  cnt_d   = (cnt > DepthC) ? DepthC : cnt;
                  state_d = StFetch;
               end
            end
         end
         StFetch: begin
            if (src_valid) begin
               wr_ptr_d = wr_ptr_q + CW'(1);
               shadow_d = shadow_q + src_data;
               if (wr_ptr_d == cnt_q) state_d = StFeed;
            end
         end
         StFeed: begin
            rd_ptr_d = rd_ptr_q + CW'(1);
            tmo_d    = '0;
            if (rd_ptr_d == cnt_q) state_d = StWait;
         end
         StWait: begin
            if (done) begin
               res_data_d = sum;
               mismatch_d = (sum != shadow_q);
               state_d    = StHold;
            end else if (tmo_q == TmoLastC) begin
               tmo_err_d = 1'b1;
               state_d   = StErr;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         StHold: begin
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ck) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         shadow_q   <= '0;
         tmo_q      <= '0;
         res_data_q <= '0;
         mismatch_q <= 1'b0;
         tmo_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         shadow_q   <= shadow_d;
         tmo_q      <= tmo_d;
         res_data_q <= res_data_d;
         mismatch_q <= mismatch_d;
         tmo_err_q  <= tmo_err_d;
      end
   end

   // Buffer contents need no reset; pointers gate every read.
   always_ff @(posedge ck) begin
      if (accept) mem_q[wr_ptr_q[AW-1:0]] <= src_data;
   end

   assign src_ready   = (state_q == StFetch);
   assign go_l        = (state_q != StFeed);
   assign inA         = (state_q == StFeed) ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   assign res_valid   = (state_q == StHold);
   assign res_data    = res_data_q;
   assign busy        = (state_q != StIdle);
   assign mismatch    = mismatch_q;
   assign timeout_err = tmo_err_q;

endmodule
